testbasic23_reader: RTL and testbench
=====================================

// Module: testbasic23_reader
// PURPOSE
//   Consumer end of the two-port blocking (sync/notify) channel pair b_out/b_out2.
//   Reads one unsigned 32-bit word, then one signed 32-bit word, forms their
//   saturated signed sum and offers it on a third blocking output port.
//   Sits downstream of the TestBasic23 producer; phases A/B/C run strictly in order.
// PARAMETERS
//   COUNT_W        8    width of completed-transaction counter (wraps)
//   INIT_UNSIGNED  13   reset value of captured unsigned register
//   INIT_SIGNED    -7   reset value of captured signed register
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        reset, asynchronous, active-high
//   b_in           in   32       unsigned data from producer (bit[31:0])
//   b_in_sync      in   1        producer has valid b_in
//   b_in_notify    out  1        reader ready for b_in
//   b_in2          in   32       signed data from producer (integer)
//   b_in2_sync     in   1        producer has valid b_in2
//   b_in2_notify   out  1        reader ready for b_in2
//   res_out        out  32       signed saturated sum
//   res_out_sync   in   1        downstream ready to take res_out
//   res_out_notify out  1        res_out valid
//   sat_flag       out  1        last res_out was clamped
//   xfer_count     out  COUNT_W  completed A->B->C rounds, mod 2^COUNT_W
// BEHAVIOUR
//   Handshake: transfer on a port when its notify and sync are both high at a
//     rising clk edge. All notify outputs are registered; sync seen outside the
//     owning phase is ignored (no capture, no state change).
//   Reset (async): phase=SECTION_A, val_unsigned=INIT_UNSIGNED,
//     val_signed=INIT_SIGNED, b_in_notify=1, b_in2_notify=0, res_out_notify=0,
//     res_out=0, sat_flag=0, xfer_count=0. Reset mid-round abandons the round.
//   SECTION_A: b_in_notify=1. On b_in transfer: val_unsigned<=b_in,
//     b_in_notify<=0, b_in2_notify<=1, phase<=SECTION_B. Otherwise hold.
//   SECTION_B: b_in2_notify=1. On b_in2 transfer: val_signed<=b_in2;
//     sum = {2'b00,val_unsigned_new} + sign-extend34(b_in2) (34-bit signed);
//     res_out<=clamp(sum, -2^31, 2^31-1); sat_flag<=(clamped);
//     b_in2_notify<=0, res_out_notify<=1, phase<=SECTION_C.
//     Sum uses the value captured in the same round, never a stale register.
//   SECTION_C: res_out_notify=1, res_out stable. On res_out transfer:
//     res_out_notify<=0, b_in_notify<=1, xfer_count<=xfer_count+1 (wraps to 0
//     from 2^COUNT_W-1), phase<=SECTION_A. res_out and sat_flag hold until the
//     next SECTION_B transfer.
//   Latency: res_out valid one cycle after b_in2 transfer; minimum round = 3
//     cycles with all syncs held high. Exactly one notify high at any time.
//   Syncs tied high: one port transfer per cycle, A,B,C repeating, no bubbles.
// TESTING
//   Reset: rst pulse -> b_in_notify=1, b_in2_notify=0, res_out_notify=0,
//     res_out=0, xfer_count=0, phase SECTION_A.
//   Basic round: b_in=13, b_in2=-7, syncs high -> res_out=6, sat_flag=0,
//     xfer_count=1, three cycles total.
//   Positive saturation: b_in=32'hFFFF_FFFF, b_in2=1 -> res_out=32'h7FFF_FFFF,
//     sat_flag=1; b_in=0, b_in2=32'h8000_0000 -> res_out=32'h8000_0000,
//     sat_flag=0 (exact min, no clamp).
//   Out-of-phase sync: b_in2_sync high in SECTION_A, res_out_sync high in B ->
//     no capture, phase unchanged; backpressure: res_out_sync low 5 cycles ->
//     res_out and res_out_notify stable throughout.
//   Counter wrap: 256 rounds with COUNT_W=8 -> xfer_count returns to 0.
//   Async reset asserted in SECTION_C -> immediate return to reset values,
//     pending result dropped, next round starts in SECTION_A.

Source files
------------

// File: rtl/testbasic23_reader.sv
// Consumer for the b_in/b_in2 blocking channel pair: reads unsigned then signed word,
// offers their saturated signed sum on res_out; strictly ordered phases A -> B -> C.
module testbasic23_reader #(
  parameter int                 COUNT_W       = 8,
  parameter logic [31:0]        INIT_UNSIGNED = 32'd13,
  parameter logic signed [31:0] INIT_SIGNED   = -32'sd7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        b_in,
  input  logic               b_in_sync,
  output logic               b_in_notify,
  input  logic [31:0]        b_in2,
  input  logic               b_in2_sync,
  output logic               b_in2_notify,
  output logic [31:0]        res_out,
  input  logic               res_out_sync,
  output logic               res_out_notify,
  output logic               sat_flag,
  output logic [COUNT_W-1:0] xfer_count
);

  localparam logic [1:0] SECTION_A = 2'd0;
  localparam logic [1:0] SECTION_B = 2'd1;
  localparam logic [1:0] SECTION_C = 2'd2;

  logic [1:0]         phase;
  logic [31:0]        val_unsigned;
  logic signed [31:0] val_signed;

  logic a_fire, b_fire, c_fire;
  assign a_fire = (phase == SECTION_A) && b_in_notify    && b_in_sync;
  assign b_fire = (phase == SECTION_B) && b_in2_notify   && b_in2_sync;
  assign c_fire = (phase == SECTION_C) && res_out_notify && res_out_sync;

  // val_unsigned was captured earlier this round; the signed operand is the word arriving now
  logic signed [31:0] signed_new;
  logic signed [33:0] sum;
  logic               pos_ovf, neg_ovf;
  logic [31:0]        sum_clamped;

  assign signed_new = b_fire ? $signed(b_in2) : val_signed;
  assign sum        = $signed({2'b00, val_unsigned}) + {{2{signed_new[31]}}, signed_new};
  assign pos_ovf    = !sum[33] && (sum[32:31] != 2'b00);
  assign neg_ovf    =  sum[33] && (sum[32:31] != 2'b11);

  always_comb begin
    sum_clamped = sum[31:0];
    if (pos_ovf)      sum_clamped = 32'h7FFF_FFFF;
    else if (neg_ovf) sum_clamped = 32'h8000_0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase          <= SECTION_A;
      val_unsigned   <= INIT_UNSIGNED;
      val_signed     <= INIT_SIGNED;
      b_in_notify    <= 1'b1;
      b_in2_notify   <= 1'b0;
      res_out_notify <= 1'b0;
      res_out        <= 32'd0;
      sat_flag       <= 1'b0;
      xfer_count     <= '0;
    end else begin
      case (phase)
        SECTION_A: if (a_fire) begin
          val_unsigned <= b_in;
          b_in_notify  <= 1'b0;
          b_in2_notify <= 1'b1;
          phase        <= SECTION_B;
        end
        SECTION_B: if (b_fire) begin
          val_signed     <= signed_new;
          res_out        <= sum_clamped;
          sat_flag       <= pos_ovf || neg_ovf;
          b_in2_notify   <= 1'b0;
          res_out_notify <= 1'b1;
          phase          <= SECTION_C;
        end
        SECTION_C: if (c_fire) begin
          res_out_notify <= 1'b0;
          b_in_notify    <= 1'b1;
          xfer_count     <= xfer_count + 1'b1;
          phase          <= SECTION_A;
        end
        default: begin
          b_in_notify    <= 1'b1;
          b_in2_notify   <= 1'b0;
          res_out_notify <= 1'b0;
          phase          <= SECTION_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_testbasic23_reader.sv
// Directed bench for testbasic23_reader: scoreboard of expected sums, immediate-assert checks.
module tb_testbasic23_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] b_in = '0;
  logic        b_in_sync = 1'b0;
  logic        b_in_notify;
  logic [31:0] b_in2 = '0;
  logic        b_in2_sync = 1'b0;
  logic        b_in2_notify;
  logic [31:0] res_out;
  logic        res_out_sync = 1'b0;
  logic        res_out_notify;
  logic        sat_flag;
  logic [7:0]  xfer_count;

  testbasic23_reader #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .b_in2(b_in2), .b_in2_sync(b_in2_sync), .b_in2_notify(b_in2_notify),
    .res_out(res_out), .res_out_sync(res_out_sync), .res_out_notify(res_out_notify),
    .sat_flag(sat_flag), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic sat; } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact 64-bit sum, then clamp to the signed 32-bit range
  task automatic push_expected(input logic [31:0] a, input logic [31:0] b);
    longint s;
    exp_t e;
    s = longint'({32'h0, a}) + longint'({{32{b[31]}}, b});
    if (s > 64'sh7FFF_FFFF)           begin e.res = 32'h7FFF_FFFF; e.sat = 1'b1; end
    else if (s < -64'sh8000_0000)     begin e.res = 32'h8000_0000; e.sat = 1'b1; end
    else                              begin e.res = s[31:0];       e.sat = 1'b0; end
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, res_out, e.res);
      check({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, e.sat});
    end
  endtask

  task automatic wait_high(input int which, input string tag);
    int n = 0;
    logic v;
    v = (which == 0) ? b_in_notify : (which == 1) ? b_in2_notify : res_out_notify;
    while (!v && n < 50) begin
      @(negedge clk);
      n++;
      v = (which == 0) ? b_in_notify : (which == 1) ? b_in2_notify : res_out_notify;
    end
    if (!v) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sb.delete();
    exp_count = 8'd0;
    @(negedge clk);
  endtask

  // One handshaken round; inputs change only at negedges
  task automatic run_round(input logic [31:0] a, input logic [31:0] b, input string tag);
    b_in = a; b_in_sync = 1'b1;
    wait_high(0, {tag, "_A"});
    @(negedge clk); b_in_sync = 1'b0;
    b_in2 = b; b_in2_sync = 1'b1;
    wait_high(1, {tag, "_B"});
    push_expected(a, b);
    @(negedge clk); b_in2_sync = 1'b0;
    wait_high(2, {tag, "_C"});
    pop_compare(tag);
    res_out_sync = 1'b1;
    @(negedge clk); res_out_sync = 1'b0;
    exp_count++;
    check({tag, "_count"}, {24'd0, xfer_count}, {24'd0, exp_count});
  endtask

  initial begin
    logic [31:0] hold_res;
    logic [31:0] ra, rb;

    // Reset values
    rst = 1'b1;
    #3;
    check("rst_b_in_notify",  {31'd0, b_in_notify},    32'd1);
    check("rst_b_in2_notify", {31'd0, b_in2_notify},   32'd0);
    check("rst_res_notify",   {31'd0, res_out_notify}, 32'd0);
    check("rst_res_out",      res_out,                 32'd0);
    check("rst_sat",          {31'd0, sat_flag},       32'd0);
    check("rst_count",        {24'd0, xfer_count},     32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Basic round with all syncs high: one transfer per cycle, three cycles
    b_in = 32'd13; b_in2 = 32'hFFFF_FFF9;
    b_in_sync = 1'b1; b_in2_sync = 1'b1; res_out_sync = 1'b1;
    push_expected(32'd13, 32'hFFFF_FFF9);
    @(negedge clk);
    check("basic_c1_b2_notify", {31'd0, b_in2_notify}, 32'd1);
    check("basic_c1_b1_notify", {31'd0, b_in_notify},  32'd0);
    @(negedge clk);
    check("basic_c2_res_notify", {31'd0, res_out_notify}, 32'd1);
    check("basic_c2_res_is_6", res_out, 32'd6);
    pop_compare("basic");
    @(negedge clk);
    b_in_sync = 1'b0; b_in2_sync = 1'b0; res_out_sync = 1'b0;
    exp_count++;
    check("basic_c3_count", {24'd0, xfer_count}, 32'd1);
    check("basic_c3_b1_notify", {31'd0, b_in_notify}, 32'd1);

    // Saturation boundaries
    run_round(32'hFFFF_FFFF, 32'd1, "pos_sat");
    run_round(32'd0, 32'h8000_0000, "exact_min");
    run_round(32'h7FFF_FFFF, 32'd0, "exact_max");
    run_round(32'h8000_0000, 32'hFFFF_FFFF, "big_u_neg");

    // Out-of-phase syncs are ignored
    b_in2 = 32'd99; b_in2_sync = 1'b1;
    repeat (3) @(negedge clk);
    b_in2_sync = 1'b0;
    check("oop_A_b1_notify", {31'd0, b_in_notify},  32'd1);
    check("oop_A_b2_notify", {31'd0, b_in2_notify}, 32'd0);
    b_in = 32'd100; b_in_sync = 1'b1;
    @(negedge clk); b_in_sync = 1'b0;
    res_out_sync = 1'b1;
    repeat (3) @(negedge clk);
    res_out_sync = 1'b0;
    check("oop_B_b2_notify",  {31'd0, b_in2_notify},   32'd1);
    check("oop_B_res_notify", {31'd0, res_out_notify}, 32'd0);
    check("oop_B_count",      {24'd0, xfer_count},     {24'd0, exp_count});
    b_in2 = 32'hFFFF_FFCE; b_in2_sync = 1'b1;
    push_expected(32'd100, 32'hFFFF_FFCE);
    @(negedge clk); b_in2_sync = 1'b0;

    // Backpressure: result held while downstream is not ready
    hold_res = res_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_notify", {31'd0, res_out_notify}, 32'd1);
      check("bp_res_stable", res_out, hold_res);
    end
    pop_compare("oop_bp");
    res_out_sync = 1'b1;
    @(negedge clk); res_out_sync = 1'b0;
    exp_count++;
    check("oop_bp_count", {24'd0, xfer_count}, {24'd0, exp_count});

    // Counter wrap over 256 back-to-back rounds from reset
    do_reset();
    b_in_sync = 1'b1; b_in2_sync = 1'b1; res_out_sync = 1'b1;
    for (int r = 0; r < 256; r++) begin
      ra = $urandom; rb = $urandom;
      b_in = ra;
      @(negedge clk);
      b_in2 = rb;
      push_expected(ra, rb);
      @(negedge clk);
      pop_compare("stream");
      @(negedge clk);
      exp_count++;
      if (r == 254) check("count_255", {24'd0, xfer_count}, 32'd255);
    end
    b_in_sync = 1'b0; b_in2_sync = 1'b0; res_out_sync = 1'b0;
    check("count_wrap", {24'd0, xfer_count}, 32'd0);

    // Async reset while a result is pending
    run_round(32'd1, 32'd2, "pre_rst");
    b_in = 32'd50; b_in_sync = 1'b1;
    @(negedge clk); b_in_sync = 1'b0;
    b_in2 = 32'd60; b_in2_sync = 1'b1;
    @(negedge clk); b_in2_sync = 1'b0;
    check("pre_rst_in_C", {31'd0, res_out_notify}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_res_notify", {31'd0, res_out_notify}, 32'd0);
    check("arst_b1_notify",  {31'd0, b_in_notify},    32'd1);
    check("arst_res_out",    res_out,                 32'd0);
    check("arst_sat",        {31'd0, sat_flag},       32'd0);
    check("arst_count",      {24'd0, xfer_count},     32'd0);
    @(negedge clk); rst = 1'b0;
    sb.delete();
    exp_count = 8'd0;
    @(negedge clk);
    run_round(32'd20, 32'hFFFF_FFF6, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
